// File: rtl/hfc_pkg.sv
// hfc_pkg: shared definitions for the hazard/forwarding controller.
//   fwd_sel_e  - operand-source select encodings driven on fwd_a/fwd_b
//   slot_t     - one shadow-pipeline slot (valid, wen, waddr, is_load)
//   src_match  - source-vs-slot dependency compare
//   fwd_pick   - forward select, younger producer first
package hfc_pkg;

  // Slot addresses are stored at a fixed width so the record type can live
  // here; the top zero-extends its AW-bit addresses (AW must not exceed this).
  localparam int unsigned HFC_AW_MAX = 8;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_MEMWB = 2'd1,
    FWD_EXMEM = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic                  valid;
    logic                  wen;
    logic [HFC_AW_MAX-1:0] waddr;
    logic                  is_load;
  } slot_t;

  function automatic logic src_match(input logic                  used,
                                     input logic [HFC_AW_MAX-1:0] addr,
                                     input slot_t                 s,
                                     input logic                  r0_hard);
    return used && s.valid && s.wen && (addr == s.waddr) &&
           !(r0_hard && (addr == '0));
  endfunction

  function automatic fwd_sel_e fwd_pick(input logic m_ex, input logic m_mem);
    if (m_ex)       return FWD_EXMEM;
    else if (m_mem) return FWD_MEMWB;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/hfc_shadow_pipe.sv
// hfc_shadow_pipe: three-slot shadow of the EX/MEM/WB stages.
//   clk, rst : clock, synchronous active-high reset (clears every slot)
//   hold     : freeze all slots (multi-cycle EX in progress)
//   ex_in    : record entering EX (all-zero for a bubble)
//   ex_q, mem_q, wb_q : current slot contents
module hfc_shadow_pipe
  import hfc_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  hold,
  input  slot_t ex_in,
  output slot_t ex_q,
  output slot_t mem_q,
  output slot_t wb_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!hold) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_in;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: RAW hazard detection, stall/flush control and operand
// forwarding select for a 5-stage pipeline.
//   clk, rst          : clock, synchronous active-high reset
//   id_*              : instruction in ID (sources, destination, load flag)
//   ex_branch_taken   : taken branch resolved in EX -> squash ID
//   ex_busy           : multi-cycle EX op -> freeze the pipeline
//   pc_stall, ifid_stall, idex_bubble, if_flush : pipeline controls
//   fwd_a, fwd_b      : registered operand-source select for the EX instruction
//   stall_cycles      : saturating count of cycles with pc_stall=1
module hazard_fwd_ctrl
  import hfc_pkg::*;
#(
  parameter int unsigned AW      = 4,
  parameter bit          FWD_EN  = 1'b1,
  parameter bit          R0_HARD = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic          id_rs_used,
  input  logic [AW-1:0] id_rt,
  input  logic          id_rt_used,
  input  logic          id_wen,
  input  logic [AW-1:0] id_waddr,
  input  logic          id_is_load,
  input  logic          ex_branch_taken,
  input  logic          ex_busy,
  output logic          pc_stall,
  output logic          ifid_stall,
  output logic          idex_bubble,
  output logic          if_flush,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic [15:0]   stall_cycles
);

  slot_t                 ex_s, mem_s, wb_s, ex_in;
  logic [HFC_AW_MAX-1:0] rs_x, rt_x;
  logic                  a_ex, a_mem, b_ex, b_mem;
  logic                  hazard, flush, stall_hz, issue;
  logic [1:0]            unused_slot_bits;

  hfc_shadow_pipe u_pipe (
    .clk   (clk),
    .rst   (rst),
    .hold  (ex_busy),
    .ex_in (ex_in),
    .ex_q  (ex_s),
    .mem_q (mem_s),
    .wb_q  (wb_s)
  );

  // WB never causes a hazard (write-before-read RF) and MEM load flag is moot.
  assign unused_slot_bits = {^wb_s, mem_s.is_load};

  always_comb begin
    rs_x  = HFC_AW_MAX'(id_rs);
    rt_x  = HFC_AW_MAX'(id_rt);
    a_ex  = src_match(id_rs_used, rs_x, ex_s,  R0_HARD);
    a_mem = src_match(id_rs_used, rs_x, mem_s, R0_HARD);
    b_ex  = src_match(id_rt_used, rt_x, ex_s,  R0_HARD);
    b_mem = src_match(id_rt_used, rt_x, mem_s, R0_HARD);

    if (FWD_EN) hazard = id_valid && (a_ex || b_ex) && ex_s.is_load;
    else        hazard = id_valid && (a_ex || b_ex || a_mem || b_mem);

    flush    = ex_branch_taken && !ex_busy;
    stall_hz = hazard && !ex_busy && !flush;
    issue    = id_valid && !ex_busy && !flush && !stall_hz && !rst;

    ex_in = '0;
    if (issue) begin
      ex_in.valid   = 1'b1;
      ex_in.wen     = id_wen;
      ex_in.waddr   = HFC_AW_MAX'(id_waddr);
      ex_in.is_load = id_is_load;
    end

    pc_stall    = !rst && (ex_busy || stall_hz);
    ifid_stall  = pc_stall;
    idex_bubble = !rst && !ex_busy && (flush || stall_hz);
    if_flush    = !rst && flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end else if (!ex_busy) begin
      if (issue && FWD_EN) begin
        fwd_a <= fwd_pick(a_ex, a_mem);
        fwd_b <= fwd_pick(b_ex, b_mem);
      end else begin
        fwd_a <= FWD_RF;
        fwd_b <= FWD_RF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                  stall_cycles <= '0;
    else if (pc_stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 16'd1;
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, id_wen, id_is_load;
  logic [3:0] id_rs, id_rt, id_waddr;
  logic       ex_branch_taken, ex_busy;

  logic        pc1, ifid1, bub1, fl1;
  logic [1:0]  fa1, fb1;
  logic [15:0] sc1;
  logic        pc0, ifid0, bub0, fl0;
  logic [1:0]  fa0, fb0;
  logic [15:0] sc0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.AW(4), .FWD_EN(1'b1), .R0_HARD(1'b1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used), .id_wen(id_wen), .id_waddr(id_waddr),
    .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken), .ex_busy(ex_busy),
    .pc_stall(pc1), .ifid_stall(ifid1), .idex_bubble(bub1), .if_flush(fl1),
    .fwd_a(fa1), .fwd_b(fb1), .stall_cycles(sc1));

  hazard_fwd_ctrl #(.AW(4), .FWD_EN(1'b0), .R0_HARD(1'b1)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used), .id_wen(id_wen), .id_waddr(id_waddr),
    .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken), .ex_busy(ex_busy),
    .pc_stall(pc0), .ifid_stall(ifid0), .idex_bubble(bub0), .if_flush(fl0),
    .fwd_a(fa0), .fwd_b(fb0), .stall_cycles(sc0));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [3:0] rs, input logic rsu,
                        input logic [3:0] rt, input logic rtu, input logic wen,
                        input logic [3:0] wa, input logic ld);
    id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_wen = wen; id_waddr = wa; id_is_load = ld;
  endtask

  task automatic idle();
    set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    ex_branch_taken = 1'b0;
    ex_busy = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset with aggressive inputs: all controls must stay low.
    rst = 1'b1;
    set_id(1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1);
    ex_branch_taken = 1'b1;
    ex_busy = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    chk("rst_pc_stall", pc1, 0);
    chk("rst_ifid", ifid1, 0);
    chk("rst_bubble", bub1, 0);
    chk("rst_flush", fl1, 0);
    chk("rst_fwd_a", fa1, 0);
    chk("rst_stall_cnt", sc1, 0);

    // ADD r3 then SUB r4,r3,r2: forward from EX/MEM, no stall.
    do_reset();
    set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b0); #1;
    chk("add_no_stall", pc1, 0);
    @(negedge clk);
    set_id(1'b1, 4'd3, 1'b1, 4'd2, 1'b1, 1'b1, 4'd4, 1'b0); #1;
    chk("sub_no_stall", pc1, 0);
    chk("sub_no_stall_fwd0", pc0, 1);
    @(negedge clk);
    idle(); #1;
    chk("sub_fwd_a_exmem", fa1, 2);
    chk("sub_fwd_b_rf", fb1, 0);

    // LW r5 then ADD r6,r5,r1: one load-use stall, then forward from MEM/WB.
    do_reset();
    set_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1); #1;
    chk("lw_no_stall", pc1, 0);
    @(negedge clk);
    set_id(1'b1, 4'd5, 1'b1, 4'd1, 1'b1, 1'b1, 4'd6, 1'b0); #1;
    chk("lu_pc_stall", pc1, 1);
    chk("lu_ifid_stall", ifid1, 1);
    chk("lu_bubble", bub1, 1);
    chk("lu_no_flush", fl1, 0);
    @(negedge clk); #1;
    chk("lu_released", pc1, 0);
    chk("lu_bubble_fwd", fa1, 0);
    @(negedge clk);
    idle(); #1;
    chk("lu_fwd_a_memwb", fa1, 1);
    chk("lu_fwd_b_rf", fb1, 0);
    chk("lu_stall_cnt", sc1, 1);

    // No forwarding: ADD r3 then a use of r3 stalls two cycles.
    do_reset();
    set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b0);
    @(negedge clk);
    set_id(1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 1'b1, 4'd7, 1'b0); #1;
    chk("nf_stall1", pc0, 1);
    chk("nf_bubble1", bub0, 1);
    @(negedge clk); #1;
    chk("nf_stall2", pc0, 1);
    @(negedge clk); #1;
    chk("nf_release", pc0, 0);
    @(negedge clk);
    idle(); #1;
    chk("nf_fwd_a", fa0, 0);
    chk("nf_stall_cnt", sc0, 2);

    // Taken branch over a load-use pair: flush wins, EX gets a bubble.
    do_reset();
    set_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1);
    @(negedge clk);
    set_id(1'b1, 4'd5, 1'b1, 4'd1, 1'b1, 1'b1, 4'd6, 1'b0);
    ex_branch_taken = 1'b1; #1;
    chk("br_flush", fl1, 1);
    chk("br_bubble", bub1, 1);
    chk("br_no_stall", pc1, 0);
    @(negedge clk);
    ex_branch_taken = 1'b0;
    set_id(1'b1, 4'd5, 1'b1, 4'd6, 1'b1, 1'b1, 4'd7, 1'b0); #1;
    chk("br_after_no_stall", pc1, 0);
    chk("br_squashed_fwd", fa1, 0);
    @(negedge clk);
    idle(); #1;
    chk("br_fwd_a_lw_mem", fa1, 1);
    chk("br_fwd_b_squashed", fb1, 0);

    // r0 is hardwired: a load to r0 and a read of r0 never interact.
    do_reset();
    set_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 1'b1, 4'd0, 1'b1);
    @(negedge clk);
    set_id(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1, 4'd8, 1'b0); #1;
    chk("r0_no_stall", pc1, 0);
    chk("r0_no_stall_fwd0", pc0, 0);
    @(negedge clk);
    idle(); #1;
    chk("r0_fwd_a", fa1, 0);
    chk("r0_fwd_b", fb1, 0);

    // ex_busy for 3 cycles freezes the slots; branch ignored while busy.
    do_reset();
    set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b0);
    @(negedge clk);
    set_id(1'b1, 4'd3, 1'b1, 4'd2, 1'b1, 1'b1, 4'd4, 1'b0);
    ex_busy = 1'b1; #1;
    chk("busy1_pc", pc1, 1);
    chk("busy1_ifid", ifid1, 1);
    chk("busy1_bubble", bub1, 0);
    @(negedge clk);
    ex_branch_taken = 1'b1; #1;
    chk("busy2_pc", pc1, 1);
    chk("busy2_br_ignored", fl1, 0);
    chk("busy2_bubble", bub1, 0);
    @(negedge clk);
    ex_branch_taken = 1'b0; #1;
    chk("busy3_pc", pc1, 1);
    @(negedge clk);
    ex_busy = 1'b0; #1;
    chk("busy_done_pc", pc1, 0);
    chk("busy_stall_cnt", sc1, 3);
    @(negedge clk);
    set_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1); #1;
    chk("busy_frozen_fwd_a", fa1, 2);
    chk("busy_frozen_fwd_b", fb1, 0);

    // Reset asserted during a load-use stall.
    @(negedge clk);
    set_id(1'b1, 4'd5, 1'b1, 4'd1, 1'b1, 1'b1, 4'd6, 1'b0); #1;
    chk("pre_rst_stall", pc1, 1);
    @(negedge clk);
    rst = 1'b1; #1;
    chk("mid_rst_pc", pc1, 0);
    chk("mid_rst_bubble", bub1, 0);
    chk("mid_rst_flush", fl1, 0);
    @(negedge clk);
    rst = 1'b0; #1;
    chk("post_rst_no_stall", pc1, 0);
    chk("post_rst_cnt", sc1, 0);
    chk("post_rst_fwd_a", fa1, 0);
    @(negedge clk);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
